bank_interleave_seq: RTL
========================

Name: bank_interleave_seq

Overview:
Synthesizable DDR4 command sequencer that drives the DIMM command pins for a single rank. It activates one row in every bank, in bank-group-major or bank-major interleave order. ACT spacing enforces tRRD_S, tRRD_L and tFAW. After a tRAS hold it can optionally precharge every bank. It replaces hand-timed testbench stimulus and also serves as the front end of the emulation traffic generator.

Parameters:
BGWIDTH, 2, bank-group address width (BANKGROUPS = 2**BGWIDTH)
BAWIDTH, 2, bank address width (BANKSPERGROUP = 2**BAWIDTH)
ADDRWIDTH, 17, row/command address width; must be at least 17 (A16..A14 carry RAS/CAS/WE)
TRRD_S, 4, min ck_t cycles between ACTs to different bank groups
TRRD_L, 6, min ck_t cycles between ACTs within the same bank group
TFAW, 16, four-activate window in cycles
TRAS, 32, cycles from the last ACT to the first PRE
CNTWIDTH, 8, width of all timing counters; every timing parameter must be < 2**CNTWIDTH

Ports:
ck_t  in  1  command clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
row  in  ADDRWIDTH  row address, latched on accepted start
mode  in  1  0 = BG-major (ba inner), 1 = BA-major (bg inner); latched on start
pre_en  in  1  1 = precharge all banks after the ACT sweep; latched on start
busy  out  1  high from the accepted start through the cycle that done pulses
done  out  1  one-cycle pulse at sequence end
cs_n  out  1  chip select, active low
act_n  out  1  DDR4 ACT_n
A  out  ADDRWIDTH  address / command bits
bg  out  BGWIDTH  bank group
ba  out  BAWIDTH  bank address

Behaviour:
- Reset, asynchronous: cs_n=1, act_n=1, A=0, bg=0, ba=0, busy=0, done=0, FSM=IDLE, all counters and the FAW history cleared. Reset mid-sequence aborts immediately; no PRE is issued.
- Idle/DES outputs: cs_n=1, act_n=1, A=0. bg and ba hold their last value.
- ACT encoding, held exactly one cycle: cs_n=0, act_n=0, A=row, with bg/ba of the target bank.
- PRE encoding, single bank, held one cycle: cs_n=0, act_n=1, A16=0, A15=1, A14=0, A10=0, all other A bits 0.
- States: IDLE -> ACT_ISSUE <-> ACT_WAIT -> RAS_WAIT -> PRE_ISSUE -> DONE -> IDLE.
  - pre_en=0: the last ACT goes directly to DONE.
- Latency: start accepted at edge N; busy=1 and the first ACT are driven from edge N+1.
- Order:
  - mode 0: (bg0,ba0),(bg0,ba1),...,(bgMax,baMax).
  - mode 1: (bg0,ba0),(bg1,ba0),...,(bgMax,ba0),(bg0,ba1),...
  - Total BANKGROUPS*BANKSPERGROUP ACTs; the index counter wraps to 0 at the end of the sweep.
- ACT k (k>0) issue cycle = max(t(k-1)+gap, t(k-4)+TFAW).
  - gap = TRRD_L if bg matches ACT k-1, else TRRD_S.
  - The FAW term applies only when k>=4.
  - Implemented with a 4-entry history of ACT timestamps from a free-running CNTWIDTH counter; comparisons are modulo-safe because all intervals are < 2**CNTWIDTH.
- RAS_WAIT lasts exactly TRAS cycles after the last ACT cycle. PREs are then issued on consecutive cycles in the same bank order.
- done pulses for one cycle after the final command; busy drops on the following edge.
  - start asserted while busy is ignored.
  - start asserted in the same cycle that done pulses is ignored.
- A mode, row or pre_en change after start has no effect on the running sequence.

Test Plan:
- Reset with start held high: outputs stay at reset values and no command is issued until reset_n rises. Assert reset_n low mid-sweep at ACT 5: cs_n=1 within the same cycle and busy=0.
- Defaults, mode=0, pre_en=0, row=1: 16 ACTs relative to the first at cycles 0,6,12,18,22,28,34,40,44,50,56,62,66,72,78,84 with bg/ba as ordered and A=1 on each; done pulses one cycle after the last ACT.
- Defaults, mode=1: ACTs every 4 cycles (0..60) with bg incrementing fastest.
- TFAW=20, mode=1: ACTs at 0,4,8,12,20,24,28,32,40,...; the 16th ACT is at cycle 72.
- pre_en=1, mode=0: first PRE at last-ACT+32, then 16 consecutive PREs with A16/A15/A14/A10 = 0/1/0/0; done pulses one cycle after the final PRE.
- start pulsed while busy, and in the same cycle as done: both are ignored. A fresh start in IDLE with row=0x1FFFF, mode=1: new sweep with A=0x1FFFF.

Source files
------------

// File: rtl/bank_interleave_seq_if.sv
// rtl/bank_interleave_seq_if.sv - request and DDR4 command bus for bank_interleave_seq
//
// Ports (signals):
//   start, row, mode, pre_en : sweep request, driven by the requester (master)
//   busy, done               : sequence status, driven by the sequencer (slave)
//   cs_n, act_n, A, bg, ba   : DDR4 command pins, driven by the sequencer (slave)
interface bank_interleave_seq_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
);
  logic                 start;
  logic [ADDRWIDTH-1:0] row;
  logic                 mode;
  logic                 pre_en;
  logic                 busy;
  logic                 done;
  logic                 cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;

  modport master (
    output start, row, mode, pre_en,
    input  busy, done, cs_n, act_n, A, bg, ba
  );

  modport slave (
    input  start, row, mode, pre_en,
    output busy, done, cs_n, act_n, A, bg, ba
  );
endinterface

// File: rtl/bank_interleave_seq.sv
// rtl/bank_interleave_seq.sv - DDR4 single-rank ACT sweep sequencer with tRRD/tFAW/tRAS spacing
//
// Ports:
//   ck_t    : command clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : bank_interleave_seq_if.slave
//             start/row/mode/pre_en in; busy/done and cs_n/act_n/A/bg/ba out
module bank_interleave_seq #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int TRRD_S    = 4,
  parameter int TRRD_L    = 6,
  parameter int TFAW      = 16,
  parameter int TRAS      = 32,
  parameter int CNTWIDTH  = 8
) (
  input logic                   ck_t,
  input logic                   reset_n,
  bank_interleave_seq_if.slave  bus
);

  localparam int IW = BGWIDTH + BAWIDTH;

  localparam logic [CNTWIDTH-1:0]  RRD_S_C = CNTWIDTH'(TRRD_S);
  localparam logic [CNTWIDTH-1:0]  RRD_L_C = CNTWIDTH'(TRRD_L);
  localparam logic [CNTWIDTH-1:0]  FAW_C   = CNTWIDTH'(TFAW);
  localparam logic [CNTWIDTH-1:0]  RAS_C   = CNTWIDTH'(TRAS);
  // PRE: A16=0 (RAS_n), A15=1 (CAS_n), A14=0 (WE_n), A10=0 (single bank)
  localparam logic [ADDRWIDTH-1:0] PRE_CMD = ADDRWIDTH'(1) << 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT_ISSUE,
    S_ACT_WAIT,
    S_RAS_WAIT,
    S_PRE_ISSUE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNTWIDTH-1:0]  tick;
  logic [CNTWIDTH-1:0]  tick_nxt;
  logic [CNTWIDTH-1:0]  hist [4];   // hist[0] = most recent ACT
  logic [IW-1:0]        idx;        // next bank in sweep order
  logic [BGWIDTH-1:0]   last_bg;
  logic [ADDRWIDTH-1:0] row_q;
  logic                 mode_q;
  logic                 pre_en_q;

  logic [BGWIDTH-1:0]   tgt_bg;
  logic [BAWIDTH-1:0]   tgt_ba;
  logic [CNTWIDTH-1:0]  since_last;
  logic [CNTWIDTH-1:0]  since_4th;
  logic                 gap_ok, faw_ok, ras_ok;
  logic                 issue_act, issue_pre;

  logic                 cs_n_q, act_n_q, busy_q, done_q;
  logic [ADDRWIDTH-1:0] a_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;

  // Decisions are made for the cycle after the coming edge, so elapsed time is
  // measured against tick+1, the timestamp the new command would carry.
  assign tick_nxt   = tick + CNTWIDTH'(1);
  assign since_last = tick_nxt - hist[0];
  assign since_4th  = tick_nxt - hist[3];

  // Index idx is 0 in IDLE, so the first bank is (0,0) regardless of mode.
  always_comb begin
    tgt_bg = '0;
    tgt_ba = '0;
    if (!mode_q) {tgt_bg, tgt_ba} = idx;
    else         {tgt_ba, tgt_bg} = idx;
  end

  assign gap_ok = since_last >= ((tgt_bg == last_bg) ? RRD_L_C : RRD_S_C);
  assign faw_ok = (32'(idx) < 4) || (since_4th >= FAW_C);
  assign ras_ok = since_last >= RAS_C;

  always_comb begin
    state_nxt = state;
    issue_act = 1'b0;
    issue_pre = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          issue_act = 1'b1;
          state_nxt = S_ACT_ISSUE;
        end
      end
      S_ACT_ISSUE, S_ACT_WAIT: begin
        // idx back at 0 means the sweep's last ACT has been issued
        if (idx == '0) begin
          if (!pre_en_q) begin
            state_nxt = S_DONE;
          end else if (ras_ok) begin
            issue_pre = 1'b1;
            state_nxt = S_PRE_ISSUE;
          end else begin
            state_nxt = S_RAS_WAIT;
          end
        end else if (gap_ok && faw_ok) begin
          issue_act = 1'b1;
          state_nxt = S_ACT_ISSUE;
        end else begin
          state_nxt = S_ACT_WAIT;
        end
      end
      S_RAS_WAIT: begin
        if (ras_ok) begin
          issue_pre = 1'b1;
          state_nxt = S_PRE_ISSUE;
        end
      end
      S_PRE_ISSUE: begin
        if (idx == '0) begin
          state_nxt = S_DONE;
        end else begin
          issue_pre = 1'b1;
          state_nxt = S_PRE_ISSUE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tick     <= '0;
      hist[0]  <= '0;
      hist[1]  <= '0;
      hist[2]  <= '0;
      hist[3]  <= '0;
      idx      <= '0;
      last_bg  <= '0;
      row_q    <= '0;
      mode_q   <= 1'b0;
      pre_en_q <= 1'b0;
      cs_n_q   <= 1'b1;
      act_n_q  <= 1'b1;
      a_q      <= '0;
      bg_q     <= '0;
      ba_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick   <= tick_nxt;
      busy_q <= (state_nxt != S_IDLE);
      done_q <= (state_nxt == S_DONE);

      if (state == S_IDLE && bus.start) begin
        row_q    <= bus.row;
        mode_q   <= bus.mode;
        pre_en_q <= bus.pre_en;
      end

      if (issue_act || issue_pre) idx <= idx + IW'(1);

      if (issue_act) begin
        hist[0] <= tick_nxt;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
        last_bg <= tgt_bg;
      end

      if (issue_act) begin
        cs_n_q  <= 1'b0;
        act_n_q <= 1'b0;
        // the first ACT goes out on the accepting edge, before row_q is loaded
        a_q     <= (state == S_IDLE) ? bus.row : row_q;
        bg_q    <= tgt_bg;
        ba_q    <= tgt_ba;
      end else if (issue_pre) begin
        cs_n_q  <= 1'b0;
        act_n_q <= 1'b1;
        a_q     <= PRE_CMD;
        bg_q    <= tgt_bg;
        ba_q    <= tgt_ba;
      end else begin
        cs_n_q  <= 1'b1;
        act_n_q <= 1'b1;
        a_q     <= '0;
      end
    end
  end

  assign bus.cs_n  = cs_n_q;
  assign bus.act_n = act_n_q;
  assign bus.A     = a_q;
  assign bus.bg    = bg_q;
  assign bus.ba    = ba_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
